// File: rtl/floating_point_unit_pkg.sv
// Shared FPU types: float32 word, rounding-bit bundle, normalizer FSM states.
package floating_point_unit_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } float32_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } round_bits_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NORMALIZE = 2'd1,
    OUTPUT    = 2'd2
  } normalizer_fsm_t;

  localparam int EXP_MAX_BIASED = 255;
  localparam int NORM_SIG_WIDTH = 48;

endpackage

// File: rtl/floating_point_normalizer_lzc.sv
// Combinational leading-zero counter; all-zero input reports WIDTH.
module leading_zero_counter #(
  parameter int WIDTH = 47,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  // Scan from MSB; first set bit fixes the count.
  always_comb begin
    logic found;
    count_o = CW'(WIDTH);
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = CW'(WIDTH - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floating_point_normalizer.sv
// Multicycle post-arithmetic normalizer: wide significand + signed exponent
// in, float32 + guard/round/sticky + overflow/underflow out.
// Optional: FPU_NORMALIZER_FAST_PATH_EN lets already-normal operands skip
// the NORMALIZE state.
module floating_point_normalizer
  import floating_point_unit_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        data_valid_i,
  output logic        ready_o,
  input  logic        sign_i,
  input  logic [9:0]  exponent_i,
  input  logic [NORM_SIG_WIDTH-1:0] significand_i,
  output float32_t    result_o,
  output round_bits_t round_bits_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        data_valid_o
);

  localparam logic [5:0] SPC = 6'(SHIFT_PER_CYCLE);

  normalizer_fsm_t state_q, state_d;
  logic [47:0] sig_r, sig_d;
  // One extra exponent bit so a right step at exponent 511 cannot wrap negative.
  logic signed [10:0] exp_r, exp_d;
  logic sign_r, sign_d, sticky_r, sticky_d;

  logic [5:0]  lz, ramt, lamt;
  logic [10:0] rneed, lexp;
  logic [47:0] rmask;
  logic        fast;

  float32_t    out_res;
  round_bits_t out_rb;
  logic [7:0]  enc_exp;
  logic        out_ovf, out_unf, out_stk;

  leading_zero_counter #(.WIDTH(47)) u_lzc (.data_i(sig_r[46:0]), .count_o(lz));

  assign ready_o = (state_q == IDLE);

`ifdef FPU_NORMALIZER_FAST_PATH_EN
  assign fast = (significand_i[47:46] == 2'b01) &&
                ($signed(exponent_i) >= 10'sd1) && ($signed(exponent_i) <= 10'sd254);
`else
  assign fast = 1'b0;
`endif

  // Per-cycle shift amounts for the denormalizing right shift and the left shift.
  always_comb begin
    rneed = 11'(11'sd1 - exp_r);
    ramt  = (rneed > 11'(SPC)) ? SPC : rneed[5:0];
    rmask = ~(48'hFFFF_FFFF_FFFF << ramt);
    lexp  = 11'(exp_r - 11'sd1);
    lamt  = (lz > SPC) ? SPC : lz;
    if (11'(lamt) > lexp) lamt = lexp[5:0];
  end

  // Next-state and datapath step; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_r;
    exp_d    = exp_r;
    sign_d   = sign_r;
    sticky_d = sticky_r;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (data_valid_i) begin
          sig_d    = significand_i;
          exp_d    = {exponent_i[9], exponent_i};
          sign_d   = sign_i;
          sticky_d = 1'b0;
          state_d  = fast ? OUTPUT : NORMALIZE;
        end
        NORMALIZE: begin
          if (sig_r == '0 && !sticky_r) begin
            exp_d   = '0;
            state_d = OUTPUT;
          end else if (exp_r <= 11'sd0) begin
            sig_d    = sig_r >> ramt;
            sticky_d = sticky_r | (|(sig_r & rmask));
            exp_d    = exp_r + $signed({5'b0, ramt});
          end else if (sig_r[47]) begin
            sig_d    = {1'b0, sig_r[47:1]};
            sticky_d = sticky_r | sig_r[0];
            exp_d    = exp_r + 11'sd1;
          end else if (!sig_r[46] && exp_r > 11'sd1) begin
            sig_d = sig_r << lamt;
            exp_d = exp_r - $signed({5'b0, lamt});
          end else begin
            state_d = OUTPUT;
          end
        end
        OUTPUT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pack the normalized operand and its rounding/exception flags.
  always_comb begin
    out_stk = (|sig_r[20:0]) | sticky_r;
    enc_exp = sig_r[46] ? exp_r[7:0] : 8'h00;
    out_ovf = (exp_r >= 11'(EXP_MAX_BIASED));
    out_res = out_ovf ? {sign_r, 8'hFF, 23'h0} : {sign_r, enc_exp, sig_r[45:23]};
    out_rb  = out_ovf ? 3'b000 : {sig_r[22], sig_r[21], out_stk};
    out_unf = !out_ovf && (enc_exp == 8'h00) && ((|sig_r) || sticky_r) && (|out_rb);
  end

  // State and working registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      sig_r    <= '0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_r    <= sig_d;
      exp_r    <= exp_d;
      sign_r   <= sign_d;
      sticky_r <= sticky_d;
    end
  end

  // Output registers: loaded only when leaving OUTPUT, held otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o     <= '0;
      round_bits_o <= '0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= (state_q == OUTPUT) && !flush_i;
      if (state_q == OUTPUT && !flush_i) begin
        result_o     <= out_res;
        round_bits_o <= out_rb;
        overflow_o   <= out_ovf;
        underflow_o  <= out_unf;
      end
    end
  end

endmodule
